// File: rtl/poly_mac_mc_if.sv
// Sample stream, coefficient configuration and result bundle for poly_mac_mc.
// The master modport is the system side; the slave modport is the MAC itself.
interface poly_mac_mc_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_LINES = 5,
   parameter int CH_W       = 2
);
   logic                  flush_i;
   logic                  cfg_we_i;
   logic [CH_W-1:0]       cfg_ch_i;
   logic [ADDR_LINES-1:0] cfg_addr_i;
   logic [DATA_WIDTH-1:0] cfg_data_i;
   logic                  cfg_ready_o;
   logic [ADDR_LINES-1:0] terms_i;
   logic                  mode_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [DATA_WIDTH-1:0] in_data_i;
   logic [CH_W-1:0]       in_ch_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] out_data_o;
   logic [CH_W-1:0]       out_ch_o;
   logic                  out_ovf_o;
   logic                  busy_o;

   modport master (
      output flush_i, cfg_we_i, cfg_ch_i, cfg_addr_i, cfg_data_i,
             terms_i, mode_i, in_valid_i, in_data_i, in_ch_i, out_ready_i,
      input  cfg_ready_o, in_ready_o, out_valid_o, out_data_o, out_ch_o,
             out_ovf_o, busy_o
   );

   modport slave (
      input  flush_i, cfg_we_i, cfg_ch_i, cfg_addr_i, cfg_data_i,
             terms_i, mode_i, in_valid_i, in_data_i, in_ch_i, out_ready_i,
      output cfg_ready_o, in_ready_o, out_valid_o, out_data_o, out_ch_o,
             out_ovf_o, busy_o
   );
endinterface

// File: rtl/poly_mac_mc.sv
// Multi-channel signed fixed-point MAC: Horner polynomial evaluation (mode 0)
// or coefficient-weighted dot product over a sample stream (mode 1), saturating.
module poly_mac_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int ADDR_LINES = 5,
   parameter int NUM_CH     = 4,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input logic          clk_i,
   input logic          rstn_i,
   poly_mac_mc_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_LINES;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_ACC, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic signed [DATA_WIDTH-1:0] coef [NUM_CH][DEPTH];
   logic signed [DATA_WIDTH-1:0] acc_q, x_q;
   logic [ADDR_LINES-1:0]        k_q, n_q;
   logic [CH_W-1:0]              ch_q;
   logic                         ovf_q;
   logic                         in_ready, cfg_ready, in_hs;

   logic signed [DATA_WIDTH-1:0] mul_a, mul_b, add_b, prod_sat, sum_sat;
   logic signed [PW-1:0]         prod, prod_sh;
   logic signed [DATA_WIDTH:0]   sum;
   logic                         prod_ovf, sum_ovf;

   // Single shared multiplier and adder; operands are steered by state.
   always_comb begin
      mul_a = bus.in_data_i;
      mul_b = coef[bus.in_ch_i][0];
      add_b = '0;
      case (state_q)
         S_EVAL: begin
            mul_a = acc_q;
            mul_b = x_q;
            add_b = coef[ch_q][k_q - ADDR_LINES'(1)];
         end
         S_ACC: begin
            mul_b = coef[ch_q][k_q];
            add_b = acc_q;
         end
         default: ;
      endcase
   end

   assign prod     = {{DATA_WIDTH{mul_a[DATA_WIDTH-1]}}, mul_a} *
                     {{DATA_WIDTH{mul_b[DATA_WIDTH-1]}}, mul_b};
   assign prod_sh  = prod >>> FRAC_BITS;
   assign prod_ovf = !((&prod_sh[PW-1:DATA_WIDTH-1]) || !(|prod_sh[PW-1:DATA_WIDTH-1]));
   assign prod_sat = prod_ovf ? (prod_sh[PW-1] ? MIN_V : MAX_V) : prod_sh[DATA_WIDTH-1:0];

   assign sum      = {prod_sat[DATA_WIDTH-1], prod_sat} + {add_b[DATA_WIDTH-1], add_b};
   assign sum_ovf  = sum[DATA_WIDTH] != sum[DATA_WIDTH-1];
   assign sum_sat  = sum_ovf ? (sum[DATA_WIDTH] ? MIN_V : MAX_V) : sum[DATA_WIDTH-1:0];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready  = 1'b1;
            cfg_ready = 1'b1;
            if (bus.in_valid_i)
               state_d = bus.mode_i ? ((bus.terms_i == '0) ? S_DONE : S_ACC) : S_LOAD;
         end
         S_LOAD: state_d = (n_q == '0) ? S_DONE : S_EVAL;
         S_EVAL: if (k_q == ADDR_LINES'(1)) state_d = S_DONE;
         S_ACC: begin
            in_ready = 1'b1;
            if (bus.in_valid_i && k_q == n_q) state_d = S_DONE;
         end
         S_DONE: if (bus.out_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.flush_i) state_d = S_IDLE;
   end

   assign in_hs = bus.in_valid_i && in_ready;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q <= '0;
         x_q   <= '0;
         k_q   <= '0;
         n_q   <= '0;
         ch_q  <= '0;
         ovf_q <= 1'b0;
      end else if (bus.flush_i) begin
         acc_q <= '0;
         k_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_hs) begin
               x_q   <= bus.in_data_i;
               ch_q  <= bus.in_ch_i;
               n_q   <= bus.terms_i;
               ovf_q <= 1'b0;
               if (bus.mode_i) begin
                  acc_q <= prod_sat;
                  k_q   <= ADDR_LINES'(1);
                  ovf_q <= prod_ovf;
               end
            end
            S_LOAD: begin
               acc_q <= coef[ch_q][n_q];
               k_q   <= n_q;
            end
            S_EVAL: begin
               acc_q <= sum_sat;
               k_q   <= k_q - ADDR_LINES'(1);
               ovf_q <= ovf_q | prod_ovf | sum_ovf;
            end
            S_ACC: if (in_hs) begin
               acc_q <= sum_sat;
               ovf_q <= ovf_q | prod_ovf | sum_ovf;
               // Hold k on the final beat so N = 2**ADDR_LINES-1 never wraps.
               if (k_q != n_q) k_q <= k_q + ADDR_LINES'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: the coefficient bank is a register file that must read as zero
   // after reset, so it is reset explicitly rather than inferred as RAM.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < DEPTH; a++)
               coef[c][a] <= '0;
      end else if (bus.cfg_we_i && cfg_ready) begin
         coef[bus.cfg_ch_i][bus.cfg_addr_i] <= bus.cfg_data_i;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.cfg_ready_o = cfg_ready;
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.out_valid_o = (state_q == S_DONE);
   assign bus.out_data_o  = (state_q == S_DONE) ? acc_q : '0;
   assign bus.out_ch_o    = (state_q == S_DONE) ? ch_q  : '0;
   assign bus.out_ovf_o   = (state_q == S_DONE) && ovf_q;
endmodule

// File: tb/tb_poly_mac_mc.sv
// Randomized self-checking bench for poly_mac_mc against an arithmetic model
// of the polynomial / dot-product evaluation with Q16.16 saturation.
module tb_poly_mac_mc;
   localparam longint QMAX = 64'sd2147483647;
   localparam longint QMIN = -64'sd2147483648;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   poly_mac_mc_if #(.DATA_WIDTH(32), .ADDR_LINES(5), .CH_W(2)) bus ();

   poly_mac_mc #(
      .DATA_WIDTH(32), .FRAC_BITS(16), .ADDR_LINES(5), .NUM_CH(4)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  mc [4][32];
   int  xs [32];
   bit  m_ovf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int sat(input longint v);
      if (v > QMAX) begin m_ovf = 1'b1; return 32'h7FFF_FFFF; end
      if (v < QMIN) begin m_ovf = 1'b1; return 32'h8000_0000; end
      return int'(v);
   endfunction

   function automatic int qmul(input int a, input int b);
      longint p;
      p = (longint'(a) * longint'(b)) >>> 16;
      return sat(p);
   endfunction

   function automatic int qadd(input int a, input int b);
      return sat(longint'(a) + longint'(b));
   endfunction

   function automatic void model_eval(input int ch, input int n, input bit mode,
                                      output int res, output bit ovf);
      int acc;
      m_ovf = 1'b0;
      if (!mode) begin
         acc = mc[ch][n];
         for (int k = n; k >= 1; k--) acc = qadd(qmul(acc, xs[0]), mc[ch][k-1]);
      end else begin
         acc = qmul(xs[0], mc[ch][0]);
         for (int k = 1; k <= n; k++) acc = qadd(acc, qmul(xs[k], mc[ch][k]));
      end
      res = acc;
      ovf = m_ovf;
   endfunction

   function automatic int rand_q();
      if ($urandom_range(0, 7) == 0) return int'($urandom);
      return int'($urandom_range(0, 393216)) - 196608;
   endfunction

   task automatic cfg_write(input int ch, input int addr, input int data, input bit accept);
      @(negedge clk);
      bus.cfg_we_i   = 1'b1;
      bus.cfg_ch_i   = 2'(ch);
      bus.cfg_addr_i = 5'(addr);
      bus.cfg_data_i = data;
      @(posedge clk);
      #1 bus.cfg_we_i = 1'b0;
      if (accept) mc[ch][addr] = data;
   endtask

   task automatic send_beat(input int ch, input int n, input bit mode, input int x);
      int guard = 0;
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = x;
      bus.in_ch_i    = 2'(ch);
      bus.terms_i    = 5'(n);
      bus.mode_i     = mode;
      while (!bus.in_ready_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_wait", 32'(bus.in_ready_o), 32'd1);
      @(posedge clk);
      #1 bus.in_valid_i = 1'b0;
      bus.in_data_i = $urandom;
   endtask

   // Drives one full evaluation, checks latency and result, optionally stalls
   // the consumer for `hold` cycles while attempting a (dropped) coefficient write.
   task automatic run_eval(input int ch, input int n, input bit mode, input int hold,
                           input string tag, output logic [31:0] got);
      int exp_res;
      bit exp_ovf;
      int cyc = 0;
      logic [31:0] held;
      model_eval(ch, n, mode, exp_res, exp_ovf);
      for (int b = 0; b <= (mode ? n : 0); b++) begin
         if (b == 0) send_beat(ch, n, mode, xs[0]);
         else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), xs[b]);
         end
      end
      @(negedge clk);
      while (!bus.out_valid_o && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), mode ? 32'd0 : 32'(n + 1));
      check({tag, "_data"}, bus.out_data_o, 32'(exp_res));
      check({tag, "_ch"}, 32'(bus.out_ch_o), 32'(ch));
      check({tag, "_ovf"}, 32'(bus.out_ovf_o), 32'(exp_ovf));
      got  = bus.out_data_o;
      held = bus.out_data_o;
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            check({tag, "_cfg_ready_done"}, 32'(bus.cfg_ready_o), 32'd0);
            bus.cfg_we_i   = 1'b1;
            bus.cfg_ch_i   = 2'(ch);
            bus.cfg_addr_i = '0;
            bus.cfg_data_i = 32'h1234_5678;
         end
         @(posedge clk);
         #1 bus.cfg_we_i = 1'b0;
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(bus.out_valid_o), 32'd1);
         check({tag, "_hold_data"}, bus.out_data_o, held);
         check({tag, "_hold_in_ready"}, 32'(bus.in_ready_o), 32'd0);
      end
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1 bus.out_ready_i = 1'b0;
      @(negedge clk);
      check({tag, "_idle_valid"}, 32'(bus.out_valid_o), 32'd0);
      check({tag, "_idle_in_ready"}, 32'(bus.in_ready_o), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int ch, n;
      bit mode;
      bus.flush_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_ch_i = '0; bus.cfg_addr_i = '0;
      bus.cfg_data_i = '0; bus.terms_i = '0; bus.mode_i = 1'b0; bus.in_valid_i = 1'b0;
      bus.in_data_i = '0; bus.in_ch_i = '0; bus.out_ready_i = 1'b0;
      for (int c = 0; c < 4; c++) for (int a = 0; a < 32; a++) mc[c][a] = 0;

      #1;
      check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      check("rst_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_out_data", bus.out_data_o, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Horner, N=2: 3*x^2 + 2*x + 1 at x=2 gives 17.0
      cfg_write(1, 0, 32'h0001_0000, 1'b1);
      cfg_write(1, 1, 32'h0002_0000, 1'b1);
      cfg_write(1, 2, 32'h0003_0000, 1'b1);
      xs[0] = 32'h0002_0000;
      run_eval(1, 2, 1'b0, 0, "horner_n2", got);
      check("horner_n2_value", got, 32'h0011_0000);

      // N=0 returns c0 regardless of x
      cfg_write(2, 0, 32'h0005_0000, 1'b1);
      xs[0] = $urandom;
      run_eval(2, 0, 1'b0, 0, "horner_n0", got);
      check("horner_n0_value", got, 32'h0005_0000);

      // Dot product with gaps and toggling in_ch_i on later beats
      cfg_write(0, 0, 32'h0001_0000, 1'b1);
      cfg_write(0, 1, 32'hFFFF_0000, 1'b1);
      cfg_write(0, 2, 32'h0000_8000, 1'b1);
      cfg_write(0, 3, 32'h0002_0000, 1'b1);
      xs[0] = 32'h0004_0000; xs[1] = 32'h0002_0000; xs[2] = 32'h0002_0000; xs[3] = 32'h0001_0000;
      run_eval(0, 3, 1'b1, 0, "dot_n3", got);
      check("dot_n3_value", got, 32'h0005_0000);

      // Saturation and ovf clearing on the next evaluation
      cfg_write(3, 0, 32'h7FFF_0000, 1'b1);
      cfg_write(3, 1, 32'h7FFF_0000, 1'b1);
      xs[0] = 32'h7FFF_0000;
      run_eval(3, 1, 1'b0, 0, "sat", got);
      check("sat_value", got, 32'h7FFF_FFFF);
      xs[0] = 32'h0002_0000;
      run_eval(1, 2, 1'b0, 0, "post_sat", got);

      // Consumer stall in DONE with a write that must be dropped
      xs[0] = 32'h0003_0000;
      run_eval(1, 0, 1'b0, 5, "stall", got);
      run_eval(1, 0, 1'b0, 0, "stall_readback", got);
      check("stall_readback_value", got, 32'h0001_0000);

      // Asynchronous reset in the middle of a long Horner evaluation
      send_beat(3, 20, 1'b0, 32'h0001_0000);
      repeat (3) @(negedge clk);
      check("mid_eval_busy", 32'(bus.busy_o), 32'd1);
      rstn = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
      for (int c = 0; c < 4; c++) for (int a = 0; a < 32; a++) mc[c][a] = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      xs[0] = 32'h0002_0000;
      run_eval(1, 2, 1'b0, 0, "after_rst", got);
      check("after_rst_value", got, 32'd0);

      // Flush in the middle of a dot product keeps the coefficient bank
      cfg_write(0, 0, 32'h0001_0000, 1'b1);
      cfg_write(0, 1, 32'hFFFF_0000, 1'b1);
      cfg_write(0, 2, 32'h0000_8000, 1'b1);
      cfg_write(0, 3, 32'h0002_0000, 1'b1);
      send_beat(0, 3, 1'b1, 32'h0004_0000);
      send_beat(0, 3, 1'b1, 32'h0002_0000);
      @(negedge clk);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1 bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_busy", 32'(bus.busy_o), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
      check("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
      xs[0] = 32'h0004_0000; xs[1] = 32'h0002_0000; xs[2] = 32'h0002_0000; xs[3] = 32'h0001_0000;
      run_eval(0, 3, 1'b1, 0, "after_flush", got);
      check("after_flush_value", got, 32'h0005_0000);

      // Flush wins over a simultaneous input handshake
      @(negedge clk);
      bus.in_valid_i = 1'b1; bus.mode_i = 1'b0; bus.terms_i = 5'd2; bus.flush_i = 1'b1;
      @(posedge clk);
      #1 bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_prio_busy", 32'(bus.busy_o), 32'd0);

      // Randomized evaluations over a fully random coefficient bank
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 32; a++)
            cfg_write(c, a, rand_q(), 1'b1);
      for (int it = 0; it < 40; it++) begin
         if (it % 8 == 7)
            repeat (4) cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), rand_q(), 1'b1);
         ch   = int'($urandom_range(0, 3));
         n    = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 4));
         mode = 1'($urandom_range(0, 1));
         for (int b = 0; b < 32; b++) xs[b] = rand_q();
         run_eval(ch, n, mode, int'($urandom_range(0, 2)), $sformatf("rand%0d", it), got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/poly_mac_mc.md
Name: poly_mac_mc

Overview:
- Multi-channel, parametrised successor of the single-channel Taylor MAC.
- Evaluates per-channel polynomials p(x)=sum c_k*x^k by Horner iteration (mode 0), or a coefficient-weighted dot product over a stream of samples (mode 1).
- Signed fixed-point arithmetic with saturation. Coefficients live in a writable per-channel register bank instead of a ROM file.
- Sits between the signal FIFO (valid/ready) and the result consumer.

Parameters:
- DATA_WIDTH, 32, sample/coefficient/result width (signed two's complement).
- FRAC_BITS, 16, fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- ADDR_LINES, 5, coefficient index width; 2**ADDR_LINES coefficients per channel.
- NUM_CH, 4, channel count; CH_W = max(1, $clog2(NUM_CH)).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort to IDLE
- cfg_we_i  in  1  coefficient write strobe
- cfg_ch_i  in  CH_W  coefficient channel
- cfg_addr_i  in  ADDR_LINES  coefficient index k
- cfg_data_i  in  DATA_WIDTH  coefficient value
- cfg_ready_o  out  1  write accepted when high (IDLE only)
- terms_i  in  ADDR_LINES  highest index N; sampled on first accepted beat
- mode_i  in  1  0=Horner, 1=dot product; sampled on first beat
- in_valid_i  in  1  sample valid
- in_ready_o  out  1  sample accepted when valid&ready
- in_data_i  in  DATA_WIDTH  sample x
- in_ch_i  in  CH_W  channel; sampled on first beat only
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  DATA_WIDTH  result
- out_ch_o  out  CH_W  channel of result
- out_ovf_o  out  1  saturation occurred during this evaluation
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async):
  - State IDLE; all outputs 0 except in_ready_o=1 and cfg_ready_o=1.
  - acc, k and latches are 0; coefficient bank is cleared to 0.
- Arithmetic:
  - Product is full 2*DATA_WIDTH signed, then arithmetic right shift by FRAC_BITS (floor).
  - Sum is formed at DATA_WIDTH+1 bits, then saturated to [0x80..0, 0x7F..F].
  - Saturation of either the product or the sum sets the sticky ovf flag.
  - ovf clears on the first beat of each evaluation.
- Coefficient writes: accepted only in IDLE (cfg_we_i & cfg_ready_o); written at the clock edge. Writes outside IDLE are dropped.
- States: IDLE, LOAD, EVAL, ACC, DONE.
- IDLE:
  - in_ready_o=1.
  - On handshake: latch x, ch, N=terms_i, mode; clear ovf.
  - Mode 0: go to LOAD.
  - Mode 1: acc <= sat(x*c[ch][0]), k <= 1; go to DONE if N==0, else ACC.
- LOAD (mode 0): acc <= c[ch][N], k <= N; go to DONE if N==0, else EVAL.
- EVAL:
  - Each cycle: acc <= sat(trunc(acc*x) + c[ch][k-1]); k <= k-1.
  - When k==1 (last update), go to DONE.
  - in_ready_o=0.
  - Latency: out_valid_o rises N+1 cycles after the accepting edge.
- ACC (mode 1):
  - in_ready_o=1; each accepted beat: acc <= sat(acc + trunc(x*c[ch][k])); k <= k+1.
  - in_ch_i is ignored on these beats.
  - The beat with k==N goes to DONE; out_valid_o rises 1 cycle after the (N+1)th beat.
- DONE:
  - out_valid_o=1; out_data_o/out_ch_o/out_ovf_o are held stable until out_ready_i.
  - in_ready_o=0.
  - On handshake, go to IDLE at the next edge. No result overlap.
- flush_i: state <= IDLE, out_valid_o <= 0, acc/k cleared. flush_i has priority over any simultaneous handshake. The coefficient bank is untouched.
- Reset mid-operation: immediate IDLE; the partial result is discarded and never presented.
- N = 2**ADDR_LINES-1 is legal; k never wraps.

Test Plan:
1. FRAC_BITS=16, ch1 c0=0x00010000, c1=0x00020000, c2=0x00030000; mode 0, N=2, x=0x00020000 -> out_data_o=0x00110000 (17.0), out_ch_o=1, ovf=0, out_valid_o 3 cycles after accept.
2. ch2 c0=0x00050000, mode 0, N=0, any x -> out_data_o=0x00050000, 1 cycle after accept.
3. ch0 c0..c3 = 0x00010000, 0xFFFF0000, 0x00008000, 0x00020000; mode 1, N=3; samples 4.0, 2.0, 2.0, 1.0 with in_valid gaps -> result 0x00050000 one cycle after 4th beat; in_ch_i toggled on beats 2-4 has no effect.
4. c0=c1=0x7FFF0000, mode 0, N=1, x=0x7FFF0000 -> out_data_o=0x7FFFFFFF, out_ovf_o=1. Next clean evaluation -> out_ovf_o=0.
5. out_ready_i low for 5 cycles in DONE -> out_* stable, in_ready_o=0, cfg writes ignored (read back unchanged via a later evaluation); then handshake -> IDLE.
6. rstn_i low mid-EVAL -> out_valid_o=0, in_ready_o=1 immediately, and the next evaluation returns 0 (bank cleared). flush_i mid-ACC -> IDLE next cycle with coefficients retained.
